// File: rtl/gen_dff_pkg.sv
// Shared helpers for the gen_* register family: index width and port-count limits.
package gen_dff_pkg;

    localparam int NP_MIN = 1;
    localparam int NP_MAX = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gen_arb.sv
// One-hot arbiter. Fixed lowest-index priority by default; round-robin with a
// rotating start pointer when GEN_MPDFFREN_RR_EN is defined.
module gen_arb
    import gen_dff_pkg::*;
#(
    parameter int NP = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NP-1:0]        req,
    input  logic                 adv,
    output logic [NP-1:0]        gnt,
    output logic [idx_w(NP)-1:0] gnt_idx
);

    localparam int IW = idx_w(NP);

`ifdef GEN_MPDFFREN_RR_EN
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    always_comb begin
        int  idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        // Search starts at ptr and wraps so every port is visited once.
        for (int k = 0; k < NP; k++) begin
            idx = (int'(ptr_q) + k) % NP;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv) ptr_d = IW'((int'(gnt_idx) + 1) % NP);
    end

    always_ff @(posedge CLK) begin
        if (RST) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NP; k++) begin
            if (!found && req[k]) begin
                found    = 1'b1;
                gnt[k]   = 1'b1;
                gnt_idx  = IW'(k);
            end
        end
    end

    // Pointer state only exists in round-robin builds.
    logic unused_ok;
    assign unused_ok = &{1'b0, CLK, RST, adv};
`endif

endmodule

// File: rtl/gen_dffren.sv
// Enabled register cell with synchronous active-high reset to RST_VALUE.
module gen_dffren #(
    parameter int            DW        = 32,
    parameter logic [DW-1:0] RST_VALUE = {DW{1'b0}}
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) q_d = d;
    end

    always_ff @(posedge CLK) begin
        if (RST) q_q <= RST_VALUE;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/gen_mpdffren.sv
// Multi-port enabled register: NP arbitrated write ports, clear, update pulse,
// last-source index and saturating conflict counter. Macro GEN_MPDFFREN_RR_EN selects round-robin.
module gen_mpdffren
    import gen_dff_pkg::*;
#(
    parameter int            DW        = 32,
    parameter int            NP        = 4,
    parameter int            CW        = 8,
    parameter logic [DW-1:0] RST_VALUE = {DW{1'b0}}
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 clr,
    input  logic [NP-1:0]        en,
    input  logic [NP*DW-1:0]     dnxt,
    output logic [NP-1:0]        gnt,
    output logic [DW-1:0]        qout,
    output logic                 upd,
    output logic [idx_w(NP)-1:0] src,
    output logic [CW-1:0]        cflct_cnt
);

    localparam int IW = idx_w(NP);

    logic [NP-1:0] req;
    logic [IW-1:0] gnt_idx;
    logic          any_gnt;
    logic [DW-1:0] wdata;
    logic          conflict;

    logic          upd_q, upd_d;
    logic [IW-1:0] src_q, src_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Clear masks every request so the grant is all-zero while clearing.
    assign req     = en & {NP{~clr}};
    assign any_gnt = |gnt;

    gen_arb #(.NP(NP)) u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .req     (req),
        .adv     (any_gnt),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        wdata = RST_VALUE;
        if (!clr) begin
            wdata = '0;
            for (int i = 0; i < NP; i++) begin
                if (gnt[i]) wdata = wdata | dnxt[i*DW +: DW];
            end
        end
    end

    gen_dffren #(.DW(DW), .RST_VALUE(RST_VALUE)) u_q (
        .CLK (CLK),
        .RST (RST),
        .en  (clr | any_gnt),
        .d   (wdata),
        .q   (qout)
    );

    always_comb begin
        int nset;
        nset = 0;
        for (int i = 0; i < NP; i++) begin
            if (en[i]) nset = nset + 1;
        end
        conflict = !clr && (nset >= 2);
    end

    always_comb begin
        upd_d = any_gnt;
        src_d = any_gnt ? gnt_idx : src_q;
        if (clr) begin
            upd_d = upd_q;
            src_d = src_q;
        end
        cnt_d = cnt_q;
        if (conflict && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            upd_q <= 1'b0;
            src_q <= '0;
            cnt_q <= '0;
        end else begin
            upd_q <= upd_d;
            src_q <= src_d;
            cnt_q <= cnt_d;
        end
    end

    assign upd       = upd_q;
    assign src       = src_q;
    assign cflct_cnt = cnt_q;

endmodule

// File: tb/tb_gen_mpdffren.sv
// Directed bench for gen_mpdffren at DW=8, NP=4, CW=2, RST_VALUE=8'hA5.
module tb_gen_mpdffren;

    localparam int DW = 8;
    localparam int NP = 4;
    localparam int CW = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              clr;
    logic [NP-1:0]     en;
    logic [NP*DW-1:0]  dnxt;
    logic [NP-1:0]     gnt;
    logic [DW-1:0]     qout;
    logic              upd;
    logic [1:0]        src;
    logic [CW-1:0]     cflct_cnt;

    int checks = 0;
    int errors = 0;

    gen_mpdffren #(.DW(DW), .NP(NP), .CW(CW), .RST_VALUE(8'hA5)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (clr),
        .en        (en),
        .dnxt      (dnxt),
        .gnt       (gnt),
        .qout      (qout),
        .upd       (upd),
        .src       (src),
        .cflct_cnt (cflct_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST  = 1'b1;
        clr  = 1'b0;
        en   = '0;
        dnxt = {8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        tick();
        RST = 1'b0;
        chk("rst_qout", 32'(qout), 32'hA5);
        chk("rst_upd",  32'(upd), 0);
        chk("rst_src",  32'(src), 0);
        chk("rst_cnt",  32'(cflct_cnt), 0);
        chk("idle_gnt", 32'(gnt), 0);

        // Two-port conflict: lowest asserted port (1) wins in both modes after reset.
        en = 4'b1010;
        #1;
        chk("cf_gnt", 32'(gnt), 32'b0010);
        tick();
        en = '0;
        chk("cf_qout", 32'(qout), 32'h22);
        chk("cf_upd",  32'(upd), 1);
        chk("cf_src",  32'(src), 1);
        chk("cf_cnt",  32'(cflct_cnt), 1);
        tick();
        chk("hold_qout", 32'(qout), 32'h22);
        chk("hold_upd",  32'(upd), 0);
        chk("hold_cnt",  32'(cflct_cnt), 1);

        // Saturation from zero: 1,2,3,3.
        RST = 1'b1;
        tick();
        RST = 1'b0;
`ifdef GEN_MPDFFREN_RR_EN
        en = 4'b1111;
        #1; chk("rr_gnt0", 32'(gnt), 32'b0001); tick(); chk("sat_cnt0", 32'(cflct_cnt), 1);
        #1; chk("rr_gnt1", 32'(gnt), 32'b0010); tick(); chk("sat_cnt1", 32'(cflct_cnt), 2);
        #1; chk("rr_gnt2", 32'(gnt), 32'b0100); tick(); chk("sat_cnt2", 32'(cflct_cnt), 3);
        #1; chk("rr_gnt3", 32'(gnt), 32'b1000); tick(); chk("sat_cnt3", 32'(cflct_cnt), 3);
        #1; chk("rr_gnt4", 32'(gnt), 32'b0001); tick(); chk("sat_cnt4", 32'(cflct_cnt), 3);
        chk("rr_qout", 32'(qout), 32'h11);
        en = '0;
`else
        en = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fx_gnt", 32'(gnt), 32'b0001);
            tick();
            chk("sat_cnt", 32'(cflct_cnt), (i < 2) ? i + 1 : 3);
            chk("sat_qout", 32'(qout), 32'h11);
            // Rewriting the same value still pulses upd.
            chk("sat_upd", 32'(upd), 1);
            chk("sat_src", 32'(src), 0);
        end
        en = '0;
`endif
        tick();
        chk("sat_hold_cnt", 32'(cflct_cnt), 3);

        // Single write to port 2, then clear with a competing request.
        en = 4'b0100;
        tick();
        en = '0;
        chk("p2_qout", 32'(qout), 32'h33);
        chk("p2_src",  32'(src), 2);
        tick();
        clr = 1'b1;
        en  = 4'b0001;
        #1;
        chk("clr_gnt", 32'(gnt), 0);
        tick();
        clr = 1'b0;
        en  = '0;
        chk("clr_qout", 32'(qout), 32'hA5);
        chk("clr_upd",  32'(upd), 0);
        chk("clr_src",  32'(src), 2);

        // Reset mid-operation discards the concurrent request.
        dnxt = {8'h44, 8'h33, 8'h22, 8'h5A};
        en   = 4'b0001;
        tick();
        chk("mid_qout", 32'(qout), 32'h5A);
        chk("mid_upd",  32'(upd), 1);
        RST = 1'b1;
        en  = 4'b0100;
        tick();
        RST = 1'b0;
        en  = '0;
        chk("mrst_qout", 32'(qout), 32'hA5);
        chk("mrst_upd",  32'(upd), 0);
        chk("mrst_src",  32'(src), 0);
        chk("mrst_cnt",  32'(cflct_cnt), 0);
        tick();
        chk("mrst_hold_qout", 32'(qout), 32'hA5);
        chk("mrst_hold_upd",  32'(upd), 0);

        // Pointer restarts at 0 after reset: with port 3 and 0 requesting, port 0 wins.
        en = 4'b1001;
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'b0001);
        en = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
